l1_axi_responder: RTL and testbench

- AXI4 responder (slave) terminating the 32-bit `m_axi_l1_V` master port driven by application task units.
- Backs the port with an on-chip word-addressed scratchpad.
- Serves single-beat and INCR bursts of up to 16 beats, for header, edge-offset, neighbor and scratch accesses.
- Used as a standalone L1 model in unit simulation and as the small local memory for per-tile tests.

---
 rtl/l1_axi_responder_pkg.sv | 24 ++
 rtl/l1_axi_responder_sdp_ram.sv | 40 ++++
 rtl/l1_axi_responder.sv | 260 ++++++++++++++++++++++++++
 tb/tb_l1_axi_responder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1_axi_responder_pkg.sv
// Shared response codes, FSM state types and burst helpers for the L1 AXI responder.
package l1_axi_responder_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} l1_rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} l1_wr_state_t;

  function automatic logic [7:0] clamp_len(input logic [7:0] len, input int unsigned max_burst);
    if (len > 8'(max_burst - 1)) return 8'(max_burst - 1);
    return len;
  endfunction

  // True when the burst starts past the scratchpad or its last word runs off the end.
  function automatic logic burst_oob(input logic [31:0] addr, input logic [7:0] len,
                                     input int unsigned depth_log2);
    logic [32:0] last_idx;
    last_idx = {3'b000, addr[31:2]} + {25'd0, len};
    return ({1'b0, addr} >= (33'd4 << depth_log2)) ||
           (last_idx > ((33'd1 << depth_log2) - 33'd1));
  endfunction

endpackage

// File: rtl/l1_axi_responder_sdp_ram.sv
// l1_sdp_ram: simple dual-port scratchpad, byte-enabled write port and
// registered read port; a same-address read and write returns the old word.
module l1_sdp_ram #(
  parameter int MEM_DEPTH_LOG2 = 12
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we,
  input  logic [MEM_DEPTH_LOG2-1:0] waddr,
  input  logic [31:0]               wdata,
  input  logic [3:0]                wstrb,
  input  logic                      re,
  input  logic [MEM_DEPTH_LOG2-1:0] raddr,
  output logic [31:0]               rdata
);

  logic [31:0] mem [1 << MEM_DEPTH_LOG2];
  logic [31:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/l1_axi_responder.sv
// AXI4 responder backing the m_axi_l1_V port with an on-chip scratchpad.
// Optional L1_RESP_ERR_EN: out-of-range bursts answer SLVERR instead of wrapping.
//   state   | meaning
//   R_IDLE  | ARREADY high, waiting for a read address
//   R_FETCH | RAM read in flight for the current beat
//   R_DATA  | RVALID high, RDATA held until RREADY
//   W_IDLE  | AWREADY high, WREADY follows AWVALID
//   W_DATA  | accepting write beats
//   W_RESP  | BVALID high until BREADY
module l1_axi_responder
  import l1_axi_responder_pkg::*;
#(
  parameter int MEM_DEPTH_LOG2 = 12,
  parameter int MAX_BURST      = 16
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic        s_axi_l1_V_ARVALID,
  output logic        s_axi_l1_V_ARREADY,
  input  logic [31:0] s_axi_l1_V_ARADDR,
  input  logic [7:0]  s_axi_l1_V_ARLEN,
  input  logic [2:0]  s_axi_l1_V_ARSIZE,
  input  logic        s_axi_l1_V_ARID,
  output logic        s_axi_l1_V_RVALID,
  input  logic        s_axi_l1_V_RREADY,
  output logic [31:0] s_axi_l1_V_RDATA,
  output logic        s_axi_l1_V_RLAST,
  output logic        s_axi_l1_V_RID,
  output logic [1:0]  s_axi_l1_V_RRESP,
  input  logic        s_axi_l1_V_AWVALID,
  output logic        s_axi_l1_V_AWREADY,
  input  logic [31:0] s_axi_l1_V_AWADDR,
  input  logic [7:0]  s_axi_l1_V_AWLEN,
  input  logic [2:0]  s_axi_l1_V_AWSIZE,
  input  logic        s_axi_l1_V_AWID,
  input  logic        s_axi_l1_V_WVALID,
  output logic        s_axi_l1_V_WREADY,
  input  logic [31:0] s_axi_l1_V_WDATA,
  input  logic [3:0]  s_axi_l1_V_WSTRB,
  input  logic        s_axi_l1_V_WLAST,
  output logic        s_axi_l1_V_BVALID,
  input  logic        s_axi_l1_V_BREADY,
  output logic [1:0]  s_axi_l1_V_BRESP,
  output logic        s_axi_l1_V_BID
);

  localparam int AW = MEM_DEPTH_LOG2;

  l1_rd_state_t  rd_state_q, rd_state_d;
  logic [AW-1:0] rd_idx_q, rd_idx_d;
  logic [7:0]    rd_len_q, rd_len_d, rd_cnt_q, rd_cnt_d;
  logic          rd_id_q, rd_id_d, rd_err_q, rd_err_d;
  logic          rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [1:0]    rresp_q, rresp_d;

  l1_wr_state_t  wr_state_q, wr_state_d;
  logic [AW-1:0] wr_idx_q, wr_idx_d;
  logic [7:0]    wr_len_q, wr_len_d, wr_cnt_q, wr_cnt_d;
  logic          wr_id_q, wr_id_d, wr_err_q, wr_err_d;
  logic          bvalid_q, bvalid_d;
  logic [1:0]    bresp_q, bresp_d;

  logic          ram_re, ram_we;
  logic [AW-1:0] ram_raddr, ram_waddr;
  logic [31:0]   ram_rdata;

  logic [AW-1:0] ar_idx, aw_idx;
  logic [7:0]    ar_len, aw_len;
  logic          ar_err, aw_err;
  logic          unused_sig;

  assign ar_idx = s_axi_l1_V_ARADDR[AW+1:2];
  assign aw_idx = s_axi_l1_V_AWADDR[AW+1:2];
  assign ar_len = clamp_len(s_axi_l1_V_ARLEN, MAX_BURST);
  assign aw_len = clamp_len(s_axi_l1_V_AWLEN, MAX_BURST);

`ifdef L1_RESP_ERR_EN
  assign ar_err = burst_oob(s_axi_l1_V_ARADDR, ar_len, AW);
  assign aw_err = burst_oob(s_axi_l1_V_AWADDR, aw_len, AW);
`else
  assign ar_err = 1'b0;
  assign aw_err = 1'b0;
`endif

  // Size is always treated as 4 bytes and the byte offset is ignored.
  assign unused_sig = ^{s_axi_l1_V_ARSIZE, s_axi_l1_V_AWSIZE, s_axi_l1_V_ARADDR[1:0],
                        s_axi_l1_V_AWADDR[1:0], s_axi_l1_V_ARADDR[31:AW+2],
                        s_axi_l1_V_AWADDR[31:AW+2]};

  // The RAM read is launched on entry to R_FETCH so its word is settled by R_DATA.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_idx_d   = rd_idx_q;
    rd_len_d   = rd_len_q;
    rd_cnt_d   = rd_cnt_q;
    rd_id_d    = rd_id_q;
    rd_err_d   = rd_err_q;
    rvalid_d   = rvalid_q;
    rlast_d    = rlast_q;
    rresp_d    = rresp_q;
    ram_re     = 1'b0;
    ram_raddr  = rd_idx_q;
    case (rd_state_q)
      R_IDLE: begin
        if (s_axi_l1_V_ARVALID) begin
          rd_idx_d   = ar_idx;
          rd_len_d   = ar_len;
          rd_cnt_d   = 8'd0;
          rd_id_d    = s_axi_l1_V_ARID;
          rd_err_d   = ar_err;
          ram_re     = 1'b1;
          ram_raddr  = ar_idx;
          rd_state_d = R_FETCH;
        end
      end
      R_FETCH: begin
        rvalid_d   = 1'b1;
        rlast_d    = (rd_cnt_q == rd_len_q);
        rresp_d    = rd_err_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        rd_state_d = R_DATA;
      end
      R_DATA: begin
        if (s_axi_l1_V_RREADY) begin
          rvalid_d = 1'b0;
          rlast_d  = 1'b0;
          if (rlast_q) begin
            rd_state_d = R_IDLE;
          end else begin
            rd_idx_d   = rd_idx_q + 1'b1;
            rd_cnt_d   = rd_cnt_q + 8'd1;
            ram_re     = 1'b1;
            ram_raddr  = rd_idx_q + 1'b1;
            rd_state_d = R_FETCH;
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wr_idx_d   = wr_idx_q;
    wr_len_d   = wr_len_q;
    wr_cnt_d   = wr_cnt_q;
    wr_id_d    = wr_id_q;
    wr_err_d   = wr_err_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    ram_we     = 1'b0;
    ram_waddr  = wr_idx_q;
    case (wr_state_q)
      W_IDLE: begin
        if (s_axi_l1_V_AWVALID) begin
          wr_idx_d   = aw_idx;
          wr_len_d   = aw_len;
          wr_cnt_d   = 8'd0;
          wr_id_d    = s_axi_l1_V_AWID;
          wr_err_d   = aw_err;
          wr_state_d = W_DATA;
          if (s_axi_l1_V_WVALID) begin
            ram_we    = !aw_err;
            ram_waddr = aw_idx;
            wr_idx_d  = aw_idx + 1'b1;
            wr_cnt_d  = 8'd1;
            if (s_axi_l1_V_WLAST || (aw_len == 8'd0)) begin
              bvalid_d   = 1'b1;
              bresp_d    = aw_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
              wr_state_d = W_RESP;
            end
          end
        end
      end
      W_DATA: begin
        if (s_axi_l1_V_WVALID) begin
          ram_we   = !wr_err_q;
          wr_idx_d = wr_idx_q + 1'b1;
          wr_cnt_d = wr_cnt_q + 8'd1;
          if (s_axi_l1_V_WLAST || (wr_cnt_q == wr_len_q)) begin
            bvalid_d   = 1'b1;
            bresp_d    = wr_err_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            wr_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (s_axi_l1_V_BREADY) begin
          bvalid_d   = 1'b0;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rd_state_q <= R_IDLE;
      rd_idx_q   <= '0;
      rd_len_q   <= '0;
      rd_cnt_q   <= '0;
      rd_id_q    <= 1'b0;
      rd_err_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rresp_q    <= AXI_RESP_OKAY;
      wr_state_q <= W_IDLE;
      wr_idx_q   <= '0;
      wr_len_q   <= '0;
      wr_cnt_q   <= '0;
      wr_id_q    <= 1'b0;
      wr_err_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= AXI_RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      rd_idx_q   <= rd_idx_d;
      rd_len_q   <= rd_len_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_id_q    <= rd_id_d;
      rd_err_q   <= rd_err_d;
      rvalid_q   <= rvalid_d;
      rlast_q    <= rlast_d;
      rresp_q    <= rresp_d;
      wr_state_q <= wr_state_d;
      wr_idx_q   <= wr_idx_d;
      wr_len_q   <= wr_len_d;
      wr_cnt_q   <= wr_cnt_d;
      wr_id_q    <= wr_id_d;
      wr_err_q   <= wr_err_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
    end
  end

  l1_sdp_ram #(.MEM_DEPTH_LOG2(AW)) u_ram (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (s_axi_l1_V_WDATA),
    .wstrb (s_axi_l1_V_WSTRB),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign s_axi_l1_V_ARREADY = (rd_state_q == R_IDLE);
  assign s_axi_l1_V_RVALID  = rvalid_q;
  assign s_axi_l1_V_RDATA   = rd_err_q ? 32'd0 : ram_rdata;
  assign s_axi_l1_V_RLAST   = rlast_q;
  assign s_axi_l1_V_RID     = rd_id_q;
  assign s_axi_l1_V_RRESP   = rresp_q;
  assign s_axi_l1_V_AWREADY = (wr_state_q == W_IDLE);
  assign s_axi_l1_V_WREADY  = (wr_state_q == W_IDLE) ? s_axi_l1_V_AWVALID : (wr_state_q == W_DATA);
  assign s_axi_l1_V_BVALID  = bvalid_q;
  assign s_axi_l1_V_BRESP   = bresp_q;
  assign s_axi_l1_V_BID     = wr_id_q;

endmodule

// File: tb/tb_l1_axi_responder.sv
// Self-checking bench for l1_axi_responder: directed cases plus randomized
// bursts checked against a word-array model of the scratchpad.
module tb_l1_axi_responder;

  localparam int DEPTH = 4096;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        arvalid = 0, arready, arid = 0, rvalid, rready = 0, rlast, rid;
  logic [31:0] araddr = 0, rdata;
  logic [7:0]  arlen = 0;
  logic [2:0]  arsize = 3'b010;
  logic [1:0]  rresp, bresp;
  logic        awvalid = 0, awready, awid = 0, wvalid = 0, wready, wlast = 0;
  logic        bvalid, bready = 0, bid;
  logic [31:0] awaddr = 0, wdata = 0;
  logic [7:0]  awlen = 0;
  logic [2:0]  awsize = 3'b010;
  logic [3:0]  wstrb = 0;

  logic [31:0] mem_m [DEPTH];
  int n_tests = 0;
  int n_fail = 0;

  always #5 ap_clk = ~ap_clk;

  l1_axi_responder dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_axi_l1_V_ARVALID(arvalid), .s_axi_l1_V_ARREADY(arready), .s_axi_l1_V_ARADDR(araddr),
    .s_axi_l1_V_ARLEN(arlen), .s_axi_l1_V_ARSIZE(arsize), .s_axi_l1_V_ARID(arid),
    .s_axi_l1_V_RVALID(rvalid), .s_axi_l1_V_RREADY(rready), .s_axi_l1_V_RDATA(rdata),
    .s_axi_l1_V_RLAST(rlast), .s_axi_l1_V_RID(rid), .s_axi_l1_V_RRESP(rresp),
    .s_axi_l1_V_AWVALID(awvalid), .s_axi_l1_V_AWREADY(awready), .s_axi_l1_V_AWADDR(awaddr),
    .s_axi_l1_V_AWLEN(awlen), .s_axi_l1_V_AWSIZE(awsize), .s_axi_l1_V_AWID(awid),
    .s_axi_l1_V_WVALID(wvalid), .s_axi_l1_V_WREADY(wready), .s_axi_l1_V_WDATA(wdata),
    .s_axi_l1_V_WSTRB(wstrb), .s_axi_l1_V_WLAST(wlast),
    .s_axi_l1_V_BVALID(bvalid), .s_axi_l1_V_BREADY(bready), .s_axi_l1_V_BRESP(bresp),
    .s_axi_l1_V_BID(bid)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic bit model_err(input logic [31:0] addr, input int beats);
`ifdef L1_RESP_ERR_EN
    longint a;
    a = longint'(addr);
    return (a >= 4 * DEPTH) || ((a >> 2) + beats - 1 > DEPTH - 1);
`else
    return (beats < 0) && (addr == 32'd0);
`endif
  endfunction

  function automatic void model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) mem_m[idx][8*b +: 8] = d[8*b +: 8];
  endfunction

  // rmode: 0 = always ready, 1 = two-cycle stalls, 2 = random
  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic id,
                          input int rmode, input bit chk_lat, input string tag);
    int nb, idx, got, cyc, first;
    bit err, stalled, extra;
    logic [31:0] exp_d [16];
    logic [31:0] last_d;
    nb = (len > 15) ? 16 : int'(len) + 1;
    idx = int'(addr[13:2]);
    err = model_err(addr, nb);
    got = 0; cyc = 0; first = -1; stalled = 0; extra = 0; last_d = 0;
    @(negedge ap_clk);
    arvalid = 1; araddr = addr; arlen = len; arid = id; arsize = 3'($urandom_range(0, 7));
    #1;
    while (!arready && cyc < 20) begin @(negedge ap_clk); #1; cyc++; end
    chk({tag, ":ar_accept"}, 32'(cyc < 20), 1);
    for (int i = 0; i < nb; i++) exp_d[i] = err ? 32'd0 : mem_m[(idx + i) % DEPTH];
    @(negedge ap_clk);
    arvalid = 0;
    cyc = 0;
    while (got < nb && cyc < 400) begin
      case (rmode)
        0:       rready = 1;
        1:       rready = (cyc % 4) >= 2;
        default: rready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (rvalid) begin
        if (first < 0) first = cyc;
        if (stalled) chk({tag, ":stable"}, rdata, last_d);
        if (rready) begin
          chk({tag, ":rdata"}, rdata, exp_d[got]);
          chk({tag, ":rlast"}, 32'(rlast), 32'(got == nb - 1));
          chk({tag, ":rresp"}, 32'(rresp), err ? 32'd2 : 32'd0);
          chk({tag, ":rid"}, 32'(rid), 32'(id));
          got++;
          stalled = 0;
        end else begin
          stalled = 1;
          last_d = rdata;
        end
      end
      @(negedge ap_clk);
      cyc++;
    end
    rready = 0;
    chk({tag, ":beats"}, got, nb);
    if (chk_lat) chk({tag, ":latency"}, first, 1);
    repeat (3) begin #1; extra |= rvalid; @(negedge ap_clk); end
    chk({tag, ":no_extra"}, 32'(extra), 0);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic id,
                           input bit same_cycle, input int nbeats, input bit wlast_en,
                           input logic [3:0] strb, input bit rnd, input logic [31:0] data0,
                           input logic [31:0] step, input string tag);
    int clen, idx, b, cyc;
    bit err, hs, got_b;
    logic [31:0] d;
    clen = (len > 15) ? 15 : int'(len);
    idx = int'(addr[13:2]);
    err = model_err(addr, clen + 1);
    b = 0; cyc = 0; got_b = 0;
    d = rnd ? $urandom : data0;
    @(negedge ap_clk);
    awvalid = 1; awaddr = addr; awlen = len; awid = id; awsize = 3'($urandom_range(0, 7));
    if (same_cycle) begin
      wvalid = 1; wdata = d; wstrb = strb; wlast = wlast_en && (nbeats == 1);
    end
    #1;
    while (!awready && cyc < 20) begin @(negedge ap_clk); #1; cyc++; end
    hs = same_cycle && wready;
    chk({tag, ":aw_accept"}, 32'(cyc < 20), 1);
    @(negedge ap_clk);
    awvalid = 0; wvalid = 0; wlast = 0;
    if (hs) begin
      if (!err) model_write(idx, d, strb);
      b = 1;
    end
    cyc = 0;
    while (b < nbeats && cyc < 200) begin
      d = rnd ? $urandom : data0 + 32'(b) * step;
      wvalid = ($urandom_range(0, 3) != 0); wdata = d; wstrb = strb;
      wlast = wlast_en && (b == nbeats - 1);
      #1;
      hs = wvalid && wready;
      @(negedge ap_clk);
      cyc++;
      if (hs) begin
        if (!err) model_write((idx + b) % DEPTH, d, strb);
        b++;
      end
    end
    wvalid = 0; wlast = 0;
    chk({tag, ":wbeats"}, b, nbeats);
    cyc = 0;
    while (!got_b && cyc < 100) begin
      bready = 1'($urandom_range(0, 1));
      #1;
      if (bvalid && bready) begin
        chk({tag, ":bresp"}, 32'(bresp), err ? 32'd2 : 32'd0);
        chk({tag, ":bid"}, 32'(bid), 32'(id));
        got_b = 1;
      end
      @(negedge ap_clk);
      cyc++;
    end
    bready = 0;
    chk({tag, ":bvalid_seen"}, 32'(got_b), 1);
    #1;
    chk({tag, ":bvalid_drop"}, 32'(bvalid), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got, cyc;
    repeat (3) @(negedge ap_clk);
    #1;
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_rlast", 32'(rlast), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_resp", {28'd0, rresp, bresp}, 0);
    chk("rst_ids", {30'd0, rid, bid}, 0);
    @(negedge ap_clk);
    ap_rst_n = 1;
    #1;
    chk("rst_ready", {30'd0, arready, awready}, 32'd3);

    // Known contents for words 0..63 and the top 16 words.
    for (int i = 0; i < 4; i++)
      axi_write(32'(i * 64), 8'd15, 1'b0, 1'b1, 16, 1'b1, 4'hF, 1'b1, 0, 0, "preload");
    axi_write(32'(4080 * 4), 8'd15, 1'b0, 1'b0, 16, 1'b1, 4'hF, 1'b1, 0, 0, "preload_top");

    axi_write(32'h40, 8'd0, 1'b0, 1'b1, 1, 1'b1, 4'hF, 1'b0, 32'hDEADBEEF, 0, "single_wr");
    axi_read(32'h40, 8'd0, 1'b0, 0, 1'b1, "single_rd");

    axi_write(32'h0, 8'd9, 1'b1, 1'b1, 10, 1'b1, 4'hF, 1'b0, 32'h100, 1, "pre10");
    axi_read(32'h0, 8'd9, 1'b1, 1, 1'b0, "burst10_stall");

    axi_read(32'h0, 8'd20, 1'b0, 0, 1'b0, "clamp_rd");
    axi_write(32'h80, 8'd20, 1'b1, 1'b0, 16, 1'b1, 4'hF, 1'b1, 0, 0, "clamp_wr");
    axi_write(32'h90, 8'd2, 1'b0, 1'b0, 3, 1'b0, 4'hF, 1'b1, 0, 0, "len_exit_wr");
    axi_write(32'hA0, 8'd7, 1'b1, 1'b1, 3, 1'b1, 4'hF, 1'b1, 0, 0, "early_wlast_wr");
    axi_read(32'h80, 8'd15, 1'b1, 2, 1'b0, "clamp_wr_rd");

    axi_write(32'h200 - 32'h1C0, 8'd3, 1'b0, 1'b1, 4, 1'b1, 4'hF, 1'b0, 32'hFFFFFFFF, 0, "pre_ff");
    axi_write(32'h200 - 32'h1C0, 8'd3, 1'b1, 1'b0, 4, 1'b1, 4'b0011, 1'b1, 0, 0, "strb_wr");
    axi_read(32'h200 - 32'h1C0, 8'd3, 1'b0, 0, 1'b0, "strb_rd");

    fork
      axi_read(32'h14, 8'd0, 1'b0, 0, 1'b1, "rw_same_rd");
      axi_write(32'h14, 8'd0, 1'b1, 1'b1, 1, 1'b1, 4'hF, 1'b0, 32'hCAFE0005, 0, "rw_same_wr");
    join
    axi_read(32'h14, 8'd0, 1'b0, 0, 1'b0, "rw_after_rd");

    axi_read(32'(4 * DEPTH), 8'd0, 1'b0, 0, 1'b0, "oob_rd");

    // Reset while beat 3 of a ten-beat read is pending.
    @(negedge ap_clk);
    arvalid = 1; araddr = 0; arlen = 8'd9; arid = 1;
    @(negedge ap_clk);
    arvalid = 0; rready = 1; got = 0; cyc = 0;
    while (got < 3 && cyc < 50) begin #1; if (rvalid) got++; @(negedge ap_clk); cyc++; end
    rready = 0; cyc = 0;
    #1;
    while (!rvalid && cyc < 20) begin @(negedge ap_clk); #1; cyc++; end
    chk("rst_mid:beat3_pending", 32'(rvalid), 1);
    ap_rst_n = 0;
    #1;
    chk("rst_mid:rvalid", 32'(rvalid), 0);
    chk("rst_mid:rlast", 32'(rlast), 0);
    @(negedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1;
    #1;
    chk("rst_mid:arready", 32'(arready), 1);
    axi_read(32'h0, 8'd9, 1'b1, 2, 1'b1, "post_rst_rd");

    for (int it = 0; it < 40; it++) begin
      int sel, ln, ix, cl, nb;
      bit wl;
      logic [31:0] a;
      sel = $urandom_range(0, 3);
      ln = $urandom_range(0, 20);
      ix = (sel == 2) ? $urandom_range(4080, 4095) : $urandom_range(0, 47);
      a = 32'(ix * 4 + $urandom_range(0, 3));
      if (sel == 3) a = a + 32'(4 * DEPTH);
      if ($urandom_range(0, 1) == 1) begin
        axi_read(a, 8'(ln), 1'($urandom_range(0, 1)), 2, 1'b0, "rnd_rd");
      end else begin
        cl = (ln > 15) ? 15 : ln;
        wl = 1'($urandom_range(0, 1));
        nb = wl ? $urandom_range(1, cl + 1) : cl + 1;
        axi_write(a, 8'(ln), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), nb, wl,
                  4'($urandom_range(0, 15)), 1'b1, 0, 0, "rnd_wr");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
